lsu_mem_ctrl: RTL and testbench

//  Load/store initiator driving the byte-addressed, word-write data memory (data_mem) from the core.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_mem_ctrl.sv | 116 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states, default memory size.
package lsu_pkg;

    localparam int unsigned LSU_MEM_BYTES = 1024;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_DONE
    } lsu_state_e;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: extracts/extends load data and merges sub-word store data.
// Stores pick their width from size[1:0], so an unsigned code on a store behaves as the signed width.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(mem_rd_i >> {addr_i, 3'b000});
        half_v = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

        case (size_i)
            SZ_B:    rd_o = {{24{byte_v[7]}}, byte_v};
            SZ_BU:   rd_o = {24'h0, byte_v};
            SZ_H:    rd_o = {{16{half_v[15]}}, half_v};
            SZ_HU:   rd_o = {16'h0, half_v};
            SZ_W:    rd_o = mem_rd_i;
            default: rd_o = '0;
        endcase

        merged_o = word_i;
        case (size_i[1:0])
            2'b00:   merged_o[{addr_i, 3'b000} +: 8]        = wd_i[7:0];
            2'b01:   merged_o[{addr_i[1], 4'b0000} +: 16]   = wd_i[15:0];
            2'b10:   merged_o                               = wd_i;
            default: merged_o                               = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator to a word-write data memory: classifies core requests, extends loads,
// read-modify-writes sub-word stores; latency 2 cycles (3 for SB/SH), core stalled until done.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wd,
    output logic [31:0] core_rd,
    output logic        core_done,
    output logic        core_err,
    output logic        core_stall,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    lsu_state_e  state_q;
    logic [31:0] rd_q;
    logic [31:0] word_q;
    logic        err_q;

    logic [31:0] word_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        is_word;
    logic        accept;
    logic        sw_now;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign word_addr = {core_addr[31:2], 2'b00};
    assign is_word   = (core_size[1:0] == 2'b10);

    always_comb begin
        misaligned   = (((core_size == SZ_H) || (core_size == SZ_HU)) && core_addr[0]) ||
                       ((core_size == SZ_W) && (core_addr[1:0] != 2'b00));
        out_of_range = (word_addr > MAX_ADDR);
        req_err      = !size_legal(core_size) || misaligned || out_of_range;
    end

    lsu_lane_align u_lane_align (
        .mem_rd_i (mem_rd),
        .addr_i   (core_addr[1:0]),
        .size_i   (core_size),
        .word_i   (word_q),
        .wd_i     (core_wd),
        .rd_o     (load_val),
        .merged_o (merged)
    );

    assign accept = (state_q == ST_IDLE) && core_req;
    assign sw_now = accept && !req_err && core_we && is_word;

    // Gated with rst_n so a reset asserted mid-write kills the strobe without waiting for a clock.
    assign mem_we     = rst_n && (sw_now || (state_q == ST_WR));
    assign mem_wd     = (state_q == ST_WR) ? merged : core_wd;
    assign mem_addr   = word_addr;

    assign core_done  = (state_q == ST_DONE);
    assign core_rd    = core_done ? rd_q : 32'h0;
    assign core_err   = core_done && err_q;
    assign core_stall = core_req && !core_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
            word_q  <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (core_req) begin
                        if (req_err) begin
                            err_q   <= 1'b1;
                            rd_q    <= 32'h0;
                            state_q <= ST_DONE;
                        end else if (!core_we) begin
                            rd_q    <= load_val;
                            state_q <= ST_DONE;
                        end else if (is_word) begin
                            rd_q    <= 32'h0;
                            state_q <= ST_DONE;
                        end else begin
                            word_q  <= mem_rd;
                            rd_q    <= 32'h0;
                            state_q <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed and random accesses against a byte-array reference memory.
module tb_lsu_mem_ctrl;

    localparam int MEM = 1024;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_done;
    logic        core_err;
    logic        core_stall;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] tb_mem [256];
    logic [7:0]  ref_b  [MEM];
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    int checks   = 0;
    int failures = 0;

    lsu_mem_ctrl #(.MEM_BYTES(MEM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_done  (core_done),
        .core_err   (core_err),
        .core_stall (core_stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rd = (mem_addr < 32'(MEM)) ? tb_mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (poke_en)
            tb_mem[poke_idx] <= poke_val;
        else if (mem_we && (mem_addr < 32'(MEM)))
            tb_mem[mem_addr[9:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_b[base + 3], ref_b[base + 2], ref_b[base + 1], ref_b[base]};
    endfunction

    task automatic poke(input int addr, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = 8'(addr >> 2);
        poke_val = val;
        for (int i = 0; i < 4; i++) ref_b[(addr & ~3) + i] = 8'(val >> (8 * i));
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < MEM / 4; i++)
            if (tb_mem[i] !== ref_word(4 * i)) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    // Reference model: byte-level view of the memory and the request rules.
    task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                         output int e_lat, output int e_we, output logic [31:0] e_wd);
        int n;
        logic legal;
        logic [31:0] base;
        logic [31:0] v;
        legal = (sz == 3'd0) || (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4) || (sz == 3'd5);
        n     = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        base  = a & ~32'd3;
        e_err = !legal || ((a % 32'(n)) != 0) || (base > 32'(MEM - 4));
        e_rd  = 32'h0;
        e_lat = 2;
        e_we  = 0;
        e_wd  = 32'h0;
        if (!e_err) begin
            if (!we) begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v |= 32'(ref_b[int'(a) + i]) << (8 * i);
                if (n < 4 && !sz[2] && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
                e_rd = v;
            end else begin
                for (int i = 0; i < n; i++) ref_b[int'(a) + i] = 8'(wd >> (8 * i));
                e_we  = 1;
                e_lat = (n == 4) ? 2 : 3;
                e_wd  = ref_word(int'(base));
            end
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] o_rd, output logic [31:0] o_wd);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] e_wd;
        int          e_lat;
        int          e_we;
        int          cyc;
        int          done_cyc;
        int          we_cnt;
        int          we_cyc;
        int          stall_bad;
        logic [31:0] we_addr;
        logic        got_err;
        model(we, sz, a, wd, e_err, e_rd, e_lat, e_we, e_wd);
        cyc = 0; done_cyc = 0; we_cnt = 0; we_cyc = 0; stall_bad = 0;
        we_addr = 32'h0; o_wd = 32'h0; o_rd = 32'h0; got_err = 1'b0;
        @(negedge clk);
        core_we = we; core_size = sz; core_addr = a; core_wd = wd; core_req = 1'b1;
        while (done_cyc == 0 && cyc < 8) begin
            cyc++;
            #1;
            if (mem_we) begin
                we_cnt++; we_cyc = cyc; we_addr = mem_addr; o_wd = mem_wd;
            end
            if (core_stall !== !core_done) stall_bad++;
            if (core_done) begin
                done_cyc = cyc; o_rd = core_rd; got_err = core_err; core_req = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        core_req = 1'b0;
        check({tag, ".latency"}, 32'(done_cyc), 32'(e_lat));
        check({tag, ".err"}, 32'(got_err), 32'(e_err));
        check({tag, ".we_count"}, 32'(we_cnt), 32'(e_we));
        check({tag, ".stall"}, 32'(stall_bad), 32'd0);
        if (!e_err) check({tag, ".rd"}, o_rd, e_rd);
        if (e_we != 0) begin
            check({tag, ".we_cycle"}, 32'(we_cyc), 32'(e_lat - 1));
            check({tag, ".we_addr"}, we_addr, a & ~32'd3);
            check({tag, ".wd"}, o_wd, e_wd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        logic        we;
        logic [2:0]  sz;
        logic [31:0] a;
        int          n;

        poke_en = 1'b0; poke_idx = 8'h0; poke_val = 32'h0;
        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_size = 3'b010; core_addr = 32'h0; core_wd = 32'h1;
        #12;
        check("reset.mem_we", 32'(mem_we), 32'd0);
        check("reset.done", 32'(core_done), 32'd0);
        check("reset.rd", core_rd, 32'h0);
        check("reset.err", 32'(core_err), 32'd0);
        core_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < MEM / 4; i++) poke(4 * i, $urandom);
        poke(32'h10, 32'h8899AABB);

        access("lb_11", 1'b0, 3'b000, 32'h11, 32'h0, rd, wd);
        check("lb_11.lit", rd, 32'hFFFFFFAA);
        access("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, rd, wd);
        check("lbu_13.lit", rd, 32'h00000088);
        access("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, rd, wd);
        check("lhu_12.lit", rd, 32'h00008899);
        access("lh_10", 1'b0, 3'b001, 32'h10, 32'h0, rd, wd);
        check("lh_10.lit", rd, 32'hFFFFAABB);
        access("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, rd, wd);
        check("lw_10.lit", rd, 32'h8899AABB);
        access("sb_12", 1'b1, 3'b000, 32'h12, 32'h55, rd, wd);
        check("sb_12.lit", wd, 32'h8855AABB);
        poke(32'h10, 32'h8899AABB);
        access("sh_10", 1'b1, 3'b001, 32'h10, 32'h1234, rd, wd);
        check("sh_10.lit", wd, 32'h88991234);
        access("sw_20", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rd, wd);
        access("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, rd, wd);
        check("lw_20.lit", rd, 32'hDEADBEEF);
        check_mem("mem_after_directed");

        access("err_lw_21", 1'b0, 3'b010, 32'h21, 32'h0, rd, wd);
        access("err_lh_13", 1'b0, 3'b001, 32'h13, 32'h0, rd, wd);
        access("err_sz011", 1'b0, 3'b011, 32'h10, 32'h0, rd, wd);
        access("err_sw_top", 1'b1, 3'b010, 32'(MEM), 32'hCAFEF00D, rd, wd);
        access("err_sh_top", 1'b1, 3'b001, 32'(MEM + 2), 32'h5A5A, rd, wd);
        access("sw_last", 1'b1, 3'b010, 32'(MEM - 4), 32'h0BADCAFE, rd, wd);
        check_mem("mem_after_errors");

        // Reset while an SB sits in its write cycle.
        poke(32'h40, 32'h11223344);
        @(negedge clk);
        core_we = 1'b1; core_size = 3'b000; core_addr = 32'h41; core_wd = 32'hAA; core_req = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid.we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.we", 32'(mem_we), 32'd0);
        check("rst_mid.done", 32'(core_done), 32'd0);
        check("rst_mid.rd", core_rd, 32'h0);
        check("rst_mid.err", 32'(core_err), 32'd0);
        core_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid.mem", tb_mem[8'h10], 32'h11223344);
        access("lw_after_rst", 1'b0, 3'b010, 32'h40, 32'h0, rd, wd);
        check("lw_after_rst.lit", rd, 32'h11223344);

        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                case ($urandom_range(0, 7))
                    0:       sz = 3'b011;
                    1:       sz = 3'b110;
                    2, 3:    sz = 3'b000;
                    4, 5:    sz = 3'b001;
                    default: sz = 3'b010;
                endcase
            end else begin
                sz = 3'($urandom_range(0, 7));
            end
            n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
            a = $urandom_range(0, MEM - 1);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            if ($urandom_range(0, 7) == 0) a = $urandom_range(MEM - 8, MEM + 64);
            access($sformatf("rnd%0d", k), we, sz, a, $urandom, rd, wd);
        end
        check_mem("mem_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
